// File: rtl/epoch_pkg.sv
// epoch_pkg: shared definitions for the epoch data feeder slice.
//   - Default widths and epoch length used by the top and the FIFO.
//   - Mode encoding (MODE_L = 0, MODE_H = 1).
//   - DATA_RST: value presented on `data` out of reset and after a flush.
//     It is non-zero so the consumer's "data is never zero" contract holds.
package epoch_pkg;

  localparam int DATA_W_DEF    = 16;
  localparam int EPOCH_LEN_DEF = 10;
  localparam int DEPTH_DEF     = 4;

  typedef enum logic {
    MODE_L = 1'b0,
    MODE_H = 1'b1
  } mode_e;

  localparam int DATA_RST = 1;

endpackage

// File: rtl/sec_fifo.sv
// sec_fifo: parameterised synchronous FIFO holding secret (H) words.
//   Ports:
//     clk, rst     clock and synchronous active-high reset
//     push, wdata  enqueue wdata (ignored when full)
//     pop          dequeue head word (ignored when empty)
//     flush        clear both pointers; contents become unreachable
//     rdata        current head word (valid when !empty)
//     full, empty  occupancy flags
//   Pointers carry one extra wrap bit: equal pointers mean empty, equal
//   index with different wrap bits means full.
module sec_fifo
  import epoch_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Flush shares the reset path: both just return the pointers to zero.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/epoch_data_feeder.sv
// epoch_data_feeder: upstream stage for the L/H epoch state machine.
//   Ports:
//     clk, rst            clock, synchronous active-high reset (L)
//     in_valid, in_data   producer word handshake (H)
//     in_ready            FIFO has room (H)
//     timer               countdown to the next epoch switch (L)
//     mode                current epoch, 0 = L, 1 = H (L)
//     data                current secret word, never zero (H)
//     data_valid          data refreshed from the FIFO this cycle (H)
//     drop_cnt            saturating count of discarded zero words (H)
//   Optional build macro SECURE_FLUSH_EN: on the H-to-L switch cycle the
//   FIFO is cleared, data returns to DATA_RST and a same-cycle push is
//   discarded without being counted.
module epoch_data_feeder
  import epoch_pkg::*;
#(
  parameter int EPOCH_LEN = EPOCH_LEN_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] timer,
  output logic              mode,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic [7:0]        drop_cnt
);

  logic [DATA_W-1:0] timer_q;
  mode_e             mode_q;
  logic [DATA_W-1:0] data_q;
  logic              data_valid_q;
  logic [7:0]        drop_q;

  logic              timer_zero;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] head;
  logic              handshake;
  logic              push;
  logic              pop;
  logic              drop;
  logic              flush;

  // Timer and mode depend only on rst and their own state, never on H inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= DATA_W'(EPOCH_LEN);
      mode_q  <= MODE_L;
    end else if (timer_q == '0) begin
      timer_q <= DATA_W'(EPOCH_LEN);
      mode_q  <= (mode_q == MODE_L) ? MODE_H : MODE_L;
    end else begin
      timer_q <= timer_q - DATA_W'(1);
    end
  end

  assign timer_zero = (timer_q == '0);

`ifdef SECURE_FLUSH_EN
  assign flush = timer_zero && (mode_q == MODE_H);
`else
  assign flush = 1'b0;
`endif

  // A zero word is still accepted from the producer but never enqueued, so
  // the consumer can never see a zero on data.
  assign in_ready  = !full;
  assign handshake = in_valid && !full;
  assign push      = handshake && (in_data != '0) && !flush;
  assign drop      = handshake && (in_data == '0) && !flush;

  // No pops on the switch cycle so data stays stable across the boundary.
  assign pop = (mode_q == MODE_H) && !timer_zero && !empty;

  sec_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (in_data),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // data_valid is a one-cycle strobe marking a fresh word on data.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      data_q       <= DATA_W'(DATA_RST);
      data_valid_q <= 1'b0;
    end else if (pop) begin
      data_q       <= head;
      data_valid_q <= 1'b1;
    end else begin
      data_valid_q <= 1'b0;
    end
  end

  // Saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
    end else if (drop && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign timer      = timer_q;
  assign mode       = mode_q;
  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_epoch_data_feeder.sv
// tb_epoch_data_feeder: self-checking bench for epoch_data_feeder.
// A queue-based model tracks the FIFO, and timer/mode are derived
// arithmetically from the number of cycles since reset. A compare process
// checks every output on each falling edge; directed literal checks pin
// the model at hand-computed points. Honours SECURE_FLUSH_EN.
module tb_epoch_data_feeder;
  import epoch_pkg::*;

  localparam int EPOCH_LEN = 10;
  localparam int DEPTH     = 4;
  localparam int DATA_W    = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [DATA_W-1:0] timer;
  logic              mode;
  logic [DATA_W-1:0] data;
  logic              data_valid;
  logic [7:0]        drop_cnt;

  int checks = 0;
  int errors = 0;

  // Model state
  int                mdl_n = 0;
  bit                mdl_active = 0;
  logic [DATA_W-1:0] mdl_q [$];
  logic [DATA_W-1:0] mdl_data = 1;
  bit                mdl_dv = 0;
  int                mdl_drop = 0;

  epoch_data_feeder #(
    .EPOCH_LEN (EPOCH_LEN),
    .DEPTH     (DEPTH),
    .DATA_W    (DATA_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .timer      (timer),
    .mode       (mode),
    .data       (data),
    .data_valid (data_valid),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int mdlTimer();
    return EPOCH_LEN - (mdl_n % (EPOCH_LEN + 1));
  endfunction

  function automatic int mdlMode();
    return (mdl_n / (EPOCH_LEN + 1)) % 2;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (n=%0d)", name, actual, expected, mdl_n);
    end
  endtask

  // Advance the model across one rising edge given the inputs for that edge.
  task automatic modelStep(input bit r, input bit v, input logic [DATA_W-1:0] d);
    int t;
    int m;
    bit ready;
    bit flush;
    if (r) begin
      mdl_n      = 0;
      mdl_active = 1;
      mdl_q.delete();
      mdl_data   = 1;
      mdl_dv     = 0;
      mdl_drop   = 0;
      return;
    end
    t     = mdlTimer();
    m     = mdlMode();
    ready = (mdl_q.size() < DEPTH);
    flush = 0;
`ifdef SECURE_FLUSH_EN
    flush = (t == 0) && (m == 1);
`endif
    if (flush) begin
      mdl_q.delete();
      mdl_data = 1;
      mdl_dv   = 0;
    end else begin
      if (m == 1 && t != 0 && mdl_q.size() > 0) begin
        mdl_data = mdl_q.pop_front();
        mdl_dv   = 1;
      end else begin
        mdl_dv = 0;
      end
      if (v && ready) begin
        if (d != 0) mdl_q.push_back(d);
        else if (mdl_drop < 255) mdl_drop++;
      end
    end
    mdl_n++;
  endtask

  // Drive one cycle of inputs, update the model, land on the next falling edge.
  task automatic applyStimulus(input bit r, input bit v, input logic [DATA_W-1:0] d);
    rst      = r;
    in_valid = v;
    in_data  = d;
    #1;
    modelStep(r, v, d);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idleUntil(input int target);
    int guard = 0;
    while (mdl_n < target && guard < 1000) begin
      applyStimulus(0, 0, '0);
      guard++;
    end
  endtask

  // Hold a word on the producer interface until it is accepted.
  task automatic pushWord(input logic [DATA_W-1:0] w);
    int guard = 0;
    bit rdy;
    do begin
      rdy = in_ready;
      applyStimulus(0, 1, w);
      guard++;
    end while (!rdy && guard < 200);
    if (!rdy) checkOutput("push_timeout", 0, 1);
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (mdl_active) begin
      checkOutput("cmp_timer", int'(timer), mdlTimer());
      checkOutput("cmp_mode", int'(mode), mdlMode());
      checkOutput("cmp_data", int'(data), int'(mdl_data));
      checkOutput("cmp_data_valid", int'(data_valid), int'(mdl_dv));
      checkOutput("cmp_drop_cnt", int'(drop_cnt), mdl_drop);
      checkOutput("cmp_in_ready", int'(in_ready), int'(mdl_q.size() < DEPTH));
      checkOutput("cmp_data_nonzero", int'(data != '0), 1);
    end
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    applyStimulus(1, 0, '0);
    applyStimulus(1, 0, '0);

    // Reset values
    checkOutput("rst_timer", int'(timer), 10);
    checkOutput("rst_mode", int'(mode), 0);
    checkOutput("rst_data", int'(data), 1);
    checkOutput("rst_data_valid", int'(data_valid), 0);
    checkOutput("rst_drop_cnt", int'(drop_cnt), 0);
    checkOutput("rst_in_ready", int'(in_ready), 1);

    // Idle 25 cycles through two epoch switches
    for (int k = 1; k <= 25; k++) begin
      applyStimulus(0, 0, '0);
      if (k == 10) begin
        checkOutput("idle_timer_zero", int'(timer), 0);
        checkOutput("idle_mode_before_switch", int'(mode), 0);
      end
      if (k == 11) begin
        checkOutput("idle_timer_reload", int'(timer), 10);
        checkOutput("idle_mode_h", int'(mode), 1);
      end
      if (k == 22) checkOutput("idle_mode_l_again", int'(mode), 0);
    end

    // Two words pushed in L mode, popped once H begins
    applyStimulus(0, 1, 16'h0005);
    applyStimulus(0, 1, 16'h0007);
    idleUntil(33);
    checkOutput("lmode_no_pop_data", int'(data), 1);
    checkOutput("lmode_no_pop_valid", int'(data_valid), 0);
    idleUntil(34);
    checkOutput("first_pop_data", int'(data), 16'h0005);
    checkOutput("first_pop_valid", int'(data_valid), 1);
    checkOutput("first_pop_timer", int'(timer), 9);
    idleUntil(35);
    checkOutput("second_pop_data", int'(data), 16'h0007);

    // Zero words are dropped and counted
    applyStimulus(0, 1, 16'h0000);
    applyStimulus(0, 1, 16'h0000);
    applyStimulus(0, 1, 16'h0003);
    applyStimulus(0, 0, '0);
    checkOutput("zero_drop_cnt", int'(drop_cnt), 2);
    checkOutput("zero_filter_data", int'(data), 16'h0003);

    // Fill the FIFO in L mode; the fifth word waits for the first H pop
    idleUntil(44);
    pushWord(16'h0011);
    pushWord(16'h0012);
    pushWord(16'h0013);
    pushWord(16'h0014);
    checkOutput("full_in_ready", int'(in_ready), 0);
    pushWord(16'h0015);
    checkOutput("fifth_accept_cycle", mdl_n, 57);
    idleUntil(60);
    checkOutput("fifth_word_data", int'(data), 16'h0015);

    // Leave two words queued at the H-to-L switch, with a zero push on it
    idleUntil(66);
    for (int w = 1; w <= 12; w++) pushWord(16'h0100 + 16'(w));
    idleUntil(87);
    checkOutput("pre_switch_timer", int'(timer), 0);
    applyStimulus(0, 1, 16'h0000);
    checkOutput("post_switch_valid", int'(data_valid), 0);
    checkOutput("post_switch_in_ready", int'(in_ready), 1);
`ifdef SECURE_FLUSH_EN
    checkOutput("flush_data", int'(data), 1);
    checkOutput("flush_drop_not_counted", int'(drop_cnt), 2);
    idleUntil(100);
    checkOutput("flush_nothing_left", int'(data), 1);
`else
    checkOutput("persist_data", int'(data), 16'h010A);
    checkOutput("persist_drop_counted", int'(drop_cnt), 3);
    idleUntil(100);
    checkOutput("persist_pop1", int'(data), 16'h010B);
    idleUntil(101);
    checkOutput("persist_pop2", int'(data), 16'h010C);
`endif

    // Reset mid-H epoch with three words queued and a push in flight
    idleUntil(110);
    pushWord(16'h0021);
    pushWord(16'h0022);
    pushWord(16'h0023);
    pushWord(16'h0024);
    idleUntil(122);
    checkOutput("midh_pop_data", int'(data), 16'h0021);
    applyStimulus(1, 1, 16'h0055);
    checkOutput("midrst_timer", int'(timer), 10);
    checkOutput("midrst_mode", int'(mode), 0);
    checkOutput("midrst_data", int'(data), 1);
    checkOutput("midrst_data_valid", int'(data_valid), 0);
    checkOutput("midrst_drop_cnt", int'(drop_cnt), 0);
    checkOutput("midrst_in_ready", int'(in_ready), 1);
    idleUntil(12);
    checkOutput("midrst_fifo_cleared_data", int'(data), 1);
    checkOutput("midrst_fifo_cleared_valid", int'(data_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/epoch_data_feeder.md
Name: epoch_data_feeder

Overview:
- Upstream stage that drives the L/H epoch state machine.
- Generates the public countdown timer and L/H mode epochs.
- Buffers secret 16-bit words from an H-domain producer and presents them as the consumer's `data` input.
- Consumer contract: `data` is never zero. The timer and mode paths carry label L and never depend on H signals.

Parameters:
- EPOCH_LEN, 10, reload value of timer; one epoch lasts EPOCH_LEN+1 cycles.
- DEPTH, 4, FIFO entries (power of two, >=2).
- DATA_W, 16, width of data words and timer.

Ports:
- clk  input  1  {L} clock; all logic on posedge.
- rst  input  1  {L} synchronous, active-high reset.
- in_valid  input  1  {H} producer word valid.
- in_data  input  DATA_W  {H} producer word.
- in_ready  output  1  {H} FIFO can accept a word.
- timer  output  DATA_W  {L} countdown to the next epoch switch.
- mode  output  1  {L} current epoch; 0 = L, 1 = H.
- data  output  DATA_W  {H} current secret word; never 0.
- data_valid  output  1  {H} `data` was refreshed from the FIFO this cycle.
- drop_cnt  output  8  {H} count of zero words discarded; saturating.

Behaviour:
- Reset values (rst high at a posedge):
  - timer = EPOCH_LEN, mode = 0, data = 1, data_valid = 0, drop_cnt = 0.
  - FIFO empty, so in_ready = 1 on the following cycle.
- Timer:
  - If timer != 0: timer <= timer - 1.
  - If timer == 0: timer <= EPOCH_LEN and mode <= ~mode in the same cycle.
  - Timer never wraps below 0.
- Timer and mode logic reads no H signal. This is a hard requirement checked by the SecVerilog typecheck.
- Push rule:
  - in_ready = !full (combinational from occupancy).
  - Handshake when in_valid && in_ready.
  - Handshake with in_data != 0: word enqueued.
  - Handshake with in_data == 0: word consumed but not enqueued; drop_cnt increments, saturating at 255.
- Pop rule:
  - Pop when mode == 1 && timer != 0 && !empty, at most one pop per cycle.
  - On pop: data <= head word and data_valid <= 1 for that one cycle.
  - Otherwise: data holds its value and data_valid <= 0.
- No pop in L mode or on the switch cycle (timer == 0), so the consumer sees stable data across epoch switches.
- Simultaneous push and pop:
  - Legal when not full; occupancy is unchanged.
  - When full, in_ready = 0 even if a pop happens that cycle; there is no same-cycle refill.
- Empty with in_valid: the word is enqueued. There is no bypass to data, so at least 1 cycle of latency from push to data.
- Full: in_ready = 0; the producer must hold the word (no loss).
- Pointers are log2(DEPTH) bits plus a wrap bit. full = same index, different wrap bit; empty = equal pointers.
- Reset mid-operation: FIFO contents discarded, all state returns to reset values, any in-flight handshake ignored.

Optional Feature:
- Macro: SECURE_FLUSH_EN.
- When defined: on an H-to-L switch (timer == 0 && mode == 1):
  - FIFO pointers clear, data <= 1, data_valid <= 0.
  - A push arriving that same cycle is dropped and not counted in drop_cnt.
  - Purpose: no secret residue survives into the L epoch.
- When undefined: FIFO contents and data persist across epochs.

Decomposition:
- Shared package epoch_pkg holds:
  - DATA_W and EPOCH_LEN defaults.
  - Mode constants MODE_L = 0, MODE_H = 1.
  - Data reset constant DATA_RST = 1.
- Natural sub-module: sec_fifo, a parameterised sync FIFO.
  - Ports: push, pop, wdata, rdata, full, empty, flush.
  - All storage labelled H.
- Top level contains the timer/mode counter, the zero filter and the pop gating.

Test Plan:
- Reset, then idle 25 cycles:
  - timer follows 10, 9, ..., 0, 10.
  - mode becomes 1 at cycle 11 and 0 at cycle 22.
  - data = 1 and data_valid = 0 throughout.
- Push 0x0005 and 0x0007 during L mode:
  - No pop until mode = 1.
  - First H cycle with timer = 9: data = 0x0005, data_valid = 1.
  - Next cycle: data = 0x0007.
- Push 0x0000, 0x0000, 0x0003:
  - drop_cnt = 2.
  - Only 0x0003 ever appears on data; data is never 0.
- Fill 4 words in L mode with in_valid held high:
  - in_ready = 0 after the 4th push; the 5th word is held by the producer.
  - In H mode the 5th word is accepted the cycle after the first pop frees an entry.
- With SECURE_FLUSH_EN: leave 2 words queued at H-to-L switch:
  - Next cycle: FIFO empty, data = 1.
- Without SECURE_FLUSH_EN, same stimulus: the 2 words pop in the next H epoch.
- Assert rst mid-H epoch with 3 words queued: next cycle all reset values hold and in_ready = 1.
